// File: rtl/jk_ff_bank_cnt.sv
// N-channel falling-edge JK flip-flop bank that can also be chained
// as a synchronous up/down counter with load and terminal count.
module jk_ff_bank_cnt #(
  parameter int            N       = 4,
  parameter logic [N-1:0]  RST_VAL = '0
) (
  input  logic         Clk,
  input  logic         RD,
  input  logic [1:0]   MODE,
  input  logic         EN,
  input  logic [N-1:0] J,
  input  logic [N-1:0] K,
  input  logic [N-1:0] SD,
  input  logic [N-1:0] CD,
  input  logic         LD,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic [N-1:0] QN,
  output logic         TC
);

  localparam logic [1:0] M_JK   = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DN   = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;

  logic [N-1:0] r_q;
  logic [N-1:0] w_next;
  logic [N-1:0] w_ones;
  logic [N-1:0] w_zeros;

  // Carry/borrow terms come from pre-edge Q only, so stages
  // overridden this cycle still feed the stages above them.
  always_comb begin
    w_ones  = '0;
    w_zeros = '0;
    w_ones[0]  = 1'b1;
    w_zeros[0] = 1'b1;
    for (int i = 1; i < N; i++) begin
      w_ones[i]  = w_ones[i-1] & r_q[i-1];
      w_zeros[i] = w_zeros[i-1] & ~r_q[i-1];
    end
  end

  always_comb begin
    w_next = r_q;
    for (int i = 0; i < N; i++) begin
      if (!SD[i]) begin
        w_next[i] = 1'b1;
      end else if (!CD[i]) begin
        w_next[i] = 1'b0;
      end else if (LD) begin
        w_next[i] = D[i];
      end else if (EN && MODE != M_HOLD) begin
        case (MODE)
          M_JK: begin
            case ({J[i], K[i]})
              2'b01:   w_next[i] = 1'b0;
              2'b10:   w_next[i] = 1'b1;
              2'b11:   w_next[i] = ~r_q[i];
              default: w_next[i] = r_q[i];
            endcase
          end
          M_UP:    w_next[i] = r_q[i] ^ w_ones[i];
          M_DN:    w_next[i] = r_q[i] ^ w_zeros[i];
          default: w_next[i] = r_q[i];
        endcase
      end
    end
  end

  always_ff @(negedge Clk or negedge RD) begin
    if (!RD) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= w_next;
    end
  end

  assign Q  = r_q;
  assign QN = ~r_q;
  assign TC = EN && !LD &&
              ((MODE == M_UP && (&r_q)) ||
               (MODE == M_DN && !(|r_q)));

endmodule

// File: tb/tb_jk_ff_bank_cnt.sv
// Bench for jk_ff_bank_cnt: vector table with an expected-result
// queue, plus hand sequences for reset and rising-edge behaviour.
module tb_jk_ff_bank_cnt;

  localparam int N = 4;

  logic         Clk;
  logic         RD;
  logic [1:0]   MODE;
  logic         EN;
  logic [N-1:0] J, K, SD, CD, D;
  logic         LD;
  logic [N-1:0] Q, QN;
  logic         TC;

  int checks;
  int errors;

  typedef struct {
    logic [1:0] mode;
    logic       en;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] sd;
    logic [3:0] cd;
    logic       ld;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       tc;
  } exp_t;

  vec_t tbl[25];
  exp_t sb[$];

  jk_ff_bank_cnt #(.N(N), .RST_VAL(4'b0000)) dut (
    .Clk(Clk), .RD(RD), .MODE(MODE), .EN(EN),
    .J(J), .K(K), .SD(SD), .CD(CD), .LD(LD), .D(D),
    .Q(Q), .QN(QN), .TC(TC)
  );

  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk4(string nm, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    MODE = v.mode; EN = v.en; J = v.j; K = v.k;
    SD = v.sd; CD = v.cd; LD = v.ld; D = v.d;
  endtask

  task automatic step(vec_t v, string nm);
    exp_t e;
    drive(v);
    sb.push_back('{v.q, v.tc});
    @(negedge Clk);
    #2;
    e = sb.pop_front();
    chk4({nm, "_q"}, Q, e.q);
    chk4({nm, "_qn"}, QN, ~e.q);
    chk1({nm, "_tc"}, TC, e.tc);
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    // mode en  j      k      sd     cd     ld  d      q      tc
    tbl[0]  = '{2'b11, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 4'b0110, 4'b0110, 1'b0};
    tbl[1]  = '{2'b00, 1'b1, 4'b1100, 4'b1010, 4'hF, 4'hF, 1'b0, 4'h0, 4'b1100, 1'b0};
    tbl[2]  = '{2'b00, 1'b1, 4'b1100, 4'b1010, 4'hF, 4'hF, 1'b0, 4'h0, 4'b0100, 1'b0};
    tbl[3]  = '{2'b01, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 4'b1110, 4'b1110, 1'b0};
    tbl[4]  = '{2'b01, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 4'b1111, 1'b1};
    tbl[5]  = '{2'b01, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 4'b0000, 1'b0};
    tbl[6]  = '{2'b01, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 4'b0101, 4'b0101, 1'b0};
    tbl[7]  = '{2'b01, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 4'b0101, 1'b0};
    tbl[8]  = '{2'b01, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 4'b0101, 1'b0};
    tbl[9]  = '{2'b01, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 4'b0101, 1'b0};
    tbl[10] = '{2'b10, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 4'b0001, 4'b0001, 1'b0};
    tbl[11] = '{2'b10, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 4'b0000, 1'b1};
    tbl[12] = '{2'b10, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 4'b1111, 1'b0};
    tbl[13] = '{2'b11, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 4'b1001, 4'b1001, 1'b0};
    tbl[14] = '{2'b11, 1'b1, 4'hF, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 4'b1001, 1'b0};
    tbl[15] = '{2'b01, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 4'b0111, 4'b0111, 1'b0};
    tbl[16] = '{2'b01, 1'b1, 4'h0, 4'h0, 4'b1110, 4'b1101, 1'b0, 4'h0, 4'b1001, 1'b0};
    tbl[17] = '{2'b00, 1'b1, 4'h0, 4'h0, 4'b1011, 4'b1011, 1'b0, 4'h0, 4'b1101, 1'b0};
    tbl[18] = '{2'b01, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 4'b1110, 1'b0};
    tbl[19] = '{2'b10, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 4'b1101, 1'b0};
    tbl[20] = '{2'b01, 1'b0, 4'h0, 4'h0, 4'hF, 4'b1110, 1'b0, 4'h0, 4'b1100, 1'b0};
    tbl[21] = '{2'b00, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 4'b1111, 4'b1111, 1'b0};
    tbl[22] = '{2'b00, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 4'b1111, 1'b0};
    tbl[23] = '{2'b01, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 4'b1111, 1'b0};
    tbl[24] = '{2'b01, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 4'h0, 4'b1111, 1'b1};

    RD = 1'b0; MODE = 2'b00; EN = 1'b0; J = '0; K = '0;
    SD = '1; CD = '1; LD = 1'b0; D = '0;
    #12;
    chk4("rst_q", Q, 4'b0000);
    chk4("rst_qn", QN, 4'b1111);
    chk1("rst_tc", TC, 1'b0);
    RD = 1'b1;

    step('{2'b11, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 4'b1011, 4'b1011, 1'b0}, "pre_rst");
    #1 RD = 1'b0;
    #1;
    chk4("arst_q", Q, 4'b0000);
    chk4("arst_qn", QN, 4'b1111);
    LD = 1'b1; D = 4'b1111;
    @(negedge Clk);
    #2;
    chk4("arst_hold", Q, 4'b0000);
    RD = 1'b1;
    step('{2'b01, 1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 4'b0001, 1'b0}, "post_rst");

    for (int i = 0; i < 25; i++) begin
      step(tbl[i], $sformatf("v%0d", i));
    end

    MODE = 2'b01; EN = 1'b1; LD = 1'b0; SD = '1; CD = '1;
    @(posedge Clk);
    #1;
    chk4("rise_noeff", Q, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_ff_bank_cnt.md
Name: jk_ff_bank_cnt

Overview:
- Parametrised N-channel JK flip-flop bank with a built-in counter mode.
- In bank mode each channel behaves as an independent 74HC112-style JK flip-flop with active-low preset/clear.
- In counter modes the same stages are chained as a synchronous up or down counter with parallel load and a terminal-count flag.
- Used as the general-purpose flip-flop/counter primitive for the 74-series logic models.

Parameters:
- N, 4, number of flip-flop channels; also the counter width (N >= 1).
- RST_VAL, {N{1'b0}}, value of Q on asynchronous reset.

Ports:
- Clk input 1 : single clock; all state changes occur on the falling edge.
- RD input 1 : asynchronous active-low reset for the whole bank.
- MODE input 2 : 00 JK bank, 01 up counter, 10 down counter, 11 hold.
- EN input 1 : count/JK enable; 0 = hold (load, preset and clear still act).
- J input N : per-channel J input (MODE 00 only).
- K input N : per-channel K input (MODE 00 only).
- SD input N : per-channel synchronous preset, active-low.
- CD input N : per-channel synchronous clear, active-low.
- LD input 1 : synchronous parallel load, active-high.
- D input N : parallel load data.
- Q output N : flip-flop states.
- QN output N : ~Q, combinational.
- TC output 1 : terminal count, combinational.

Behaviour:
- Reset
  - RD=0 forces Q=RST_VAL immediately, independent of Clk; QN=~RST_VAL.
  - TC is derived from Q, MODE and EN, as defined below.
  - Q is held at RST_VAL while RD=0.
  - First update after release is at the first falling Clk edge with RD=1.
- Per-channel priority at each falling Clk edge (RD=1), highest first:
  1. SD[i]=0 -> Q[i]=1. Preset dominates clear; SD=CD=0 gives Q=1.
  2. CD[i]=0 -> Q[i]=0.
  3. LD=1 -> Q[i]=D[i], in every MODE including 11.
  4. EN=0 or MODE=11 -> Q[i] holds.
  5. MODE action, below.
- Preset/clear apply per channel, so preset/clear channels and counting channels can coexist in the same cycle.
- MODE 00 (JK bank), per channel, on Q[i]:
  - JK=00 hold.
  - JK=01 -> 0.
  - JK=10 -> 1.
  - JK=11 toggle.
- MODE 01 (up counter):
  - Stage 0 toggles every enabled edge.
  - Stage i toggles when Q[i-1:0] are all 1.
  - J and K are ignored.
  - Wraps from 2^N-1 to 0.
- MODE 10 (down counter):
  - Stage 0 toggles every enabled edge.
  - Stage i toggles when Q[i-1:0] are all 0.
  - Wraps from 0 to 2^N-1.
- Toggle terms in counter modes are computed from pre-edge Q, fully synchronous with no ripple. Channels overridden by SD/CD that cycle still feed the toggle terms of higher stages from their pre-edge value.
- Latency: one falling edge from input to Q; QN and TC are combinational from Q.
- TC:
  - 1 iff EN=1, LD=0, and either MODE=01 with Q all 1, or MODE=10 with Q all 0.
  - 0 in MODE 00 and MODE 11.
  - TC ignores SD/CD.
- N=1: the counter modes reduce to a toggle flip-flop; TC follows the rules above.
- Changing MODE mid-count takes effect at the next falling edge with no state loss.
- Rising Clk edges have no effect.

Test Plan:
- RD=0 pulsed mid-cycle while Q=4'b1011 -> Q=0000 and QN=1111 immediately. Release RD, MODE=01, EN=1 -> Q=0001 at the next falling edge.
- MODE=00, N=4, J=1100, K=1010, from Q=0110 -> next Q=1100 (ch3 toggle 0->1, ch2 set, ch1 clear, ch0 hold 0). Repeat the edge -> Q=0100.
- MODE=01, EN=1, count from 1110 -> 1111 with TC=1, then 0000 with TC=0. Hold EN=0 at 0101 for 3 edges -> stays 0101, TC=0.
- MODE=10 from 0001 -> 0000 with TC=1 -> 1111.
- LD=1, D=1001 in MODE=11 -> Q=1001.
- Per-channel override during up count at Q=0111 with SD=1110, CD=1101 on the same edge:
  - ch0 is preset to 1 and ch1 is cleared to 0.
  - ch2 toggles from pre-edge ones, 1->0; ch3 toggles 0->1.
  - Result Q=1001.
- SD[2]=0 and CD[2]=0 together in MODE=00 -> Q[2]=1.
